// File: rtl/pipe_elastic_ctrl.sv
// Elastic pipeline-register controller: NREG boundary registers, each advancing
// on its own valid/ready handshake, with partial flush and commit/occupancy counts.
module pipe_elastic_ctrl #(
  parameter int NREG  = 5,
  parameter int W     = 64,
  parameter int CNT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  input  logic [NREG*W-1:0]   nxt_data,
  input  logic [NREG-1:0]     done,
  output logic [NREG-1:0]     cur_valid,
  output logic [NREG*W-1:0]   cur_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  input  logic [2:0]          flush_upto,
  output logic [3:0]          occupancy,
  output logic [CNT_W-1:0]    commit_cnt
);

  logic [NREG-1:0]   valid_q;
  logic [NREG*W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NREG-1:0] ready;
  logic [NREG-1:0] adv;
  logic [NREG-1:0] drain;
  logic [NREG-1:0] kill;

  // Stage 0 has no upstream result and no done condition.
  logic unused_inputs;
  assign unused_inputs = ^{done[0], nxt_data[W-1:0]};

  // Ready ripples from the consumer back to the producer, so a fully moving
  // pipeline accepts a new item every cycle.
  always_comb begin
    ready = '0;
    adv   = '0;
    drain = '0;
    kill  = '0;
    ready[NREG-1] = !valid_q[NREG-1] || out_ready;
    drain[NREG-1] = out_ready;
    for (int s = NREG - 1; s >= 1; s--) begin
      adv[s]       = valid_q[s-1] && done[s] && ready[s];
      ready[s-1]   = !valid_q[s-1] || adv[s];
      drain[s-1]   = adv[s];
    end
    adv[0] = in_valid && ready[0];
    for (int s = 0; s < NREG; s++) begin
      kill[s] = flush && (flush_upto >= 3'(s));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      for (int s = 0; s < NREG; s++) begin
        if (adv[s]) begin
          data_q[s*W +: W] <= (s == 0) ? in_data : nxt_data[s*W +: W];
          valid_q[s]       <= !kill[s];
        end else if (drain[s] || kill[s]) begin
          valid_q[s] <= 1'b0;
        end
      end
      // A killed last register is not delivered, so it is not counted.
      if (valid_q[NREG-1] && out_ready && !kill[NREG-1]) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < NREG; s++) begin
      occupancy = occupancy + 4'(valid_q[s]);
    end
  end

  assign in_ready   = ready[0];
  assign cur_valid  = valid_q;
  assign cur_data   = data_q;
  assign out_valid  = valid_q[NREG-1];
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_elastic_ctrl.sv
// Directed self-checking bench for pipe_elastic_ctrl (NREG=5, W=64); each stage
// adds its index to the payload, so an item x leaves the pipeline as x+10.
module tb_pipe_elastic_ctrl;

  localparam int NREG = 5;
  localparam int W    = 64;
  localparam logic [NREG-1:0] ALL_DONE = 5'b11111;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic [NREG*W-1:0] nxt_data;
  logic [NREG-1:0]   done;
  logic [NREG-1:0]   cur_valid;
  logic [NREG*W-1:0] cur_data;
  logic              out_valid;
  logic              out_ready;
  logic              flush;
  logic [2:0]        flush_upto;
  logic [3:0]        occupancy;
  logic [63:0]       commit_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] outQ[$];

  pipe_elastic_ctrl #(.NREG(NREG), .W(W), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .nxt_data(nxt_data), .done(done), .cur_valid(cur_valid), .cur_data(cur_data),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .flush_upto(flush_upto),
    .occupancy(occupancy), .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage s computes R(s-1) + s.
  always_comb begin
    nxt_data = '0;
    for (int s = 1; s < NREG; s++) begin
      nxt_data[s*W +: W] = cur_data[(s-1)*W +: W] + 64'(s);
    end
  end

  // Record every delivered output (inputs are stable at the falling edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !(flush && flush_upto >= 3'd4)) begin
      outQ.push_back(cur_data[(NREG-1)*W +: W]);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [W-1:0] id, input logic ordy,
                               input logic [NREG-1:0] dn, input logic fl, input logic [2:0] fu);
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    done       = dn;
    flush      = fl;
    flush_upto = fu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer base, base+1, ... until n are accepted or the cycle budget expires.
  task automatic pushItems(input logic [W-1:0] base, input int n, input int maxCycles);
    int k = 0;
    int c = 0;
    while (k < n && c < maxCycles) begin
      in_valid = 1'b1;
      in_data  = base + 64'(k);
      #1;
      if (in_ready) k++;
      tick();
      c++;
    end
    in_valid = 1'b0;
    if (k < n) checkOutput("push_timeout", 64'(k), 64'(n));
  endtask

  task automatic checkQueue(input string tag, input logic [W-1:0] first, input int n);
    checkOutput({tag, "_count"}, 64'(outQ.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < outQ.size()) checkOutput({tag, "_order"}, outQ[i], first + 64'(i));
    end
    outQ.delete();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, ALL_DONE, 1'b0, 3'd0);
    #1;
    checkOutput("rst_valid", 64'(cur_valid), 64'h0);
    checkOutput("rst_commit", commit_cnt, 64'h0);
    checkOutput("rst_occ", 64'(occupancy), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
    #11;
    rst = 1'b0;
    tick();

    $display("[TB] streaming");
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_data  = 64'h11 + 64'(i);
      tick();
      if (i < 4) begin
        checkOutput("stream_latency", 64'(out_valid), 64'h0);
      end else begin
        checkOutput("stream_valid", 64'(out_valid), 64'h1);
        checkOutput("stream_data", cur_data[(NREG-1)*W +: W], 64'h1B + 64'(i - 4));
      end
    end
    in_valid = 1'b0;
    tick();
    checkOutput("stream_empty", 64'(out_valid), 64'h0);
    checkOutput("stream_commit", commit_cnt, 64'd8);
    checkQueue("stream", 64'h1B, 8);

    $display("[TB] backpressure");
    applyStimulus(1'b0, '0, 1'b0, ALL_DONE, 1'b0, 3'd0);
    pushItems(64'h31, 5, 10);
    applyStimulus(1'b1, 64'h36, 1'b0, ALL_DONE, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("bp_occ", 64'(occupancy), 64'd5);
    checkOutput("bp_in_ready", 64'(in_ready), 64'h0);
    checkOutput("bp_commit_held", commit_cnt, 64'd8);
    out_ready = 1'b1;
    pushItems(64'h36, 3, 10);
    idle(10);
    checkQueue("bp", 64'h3B, 8);
    checkOutput("bp_commit", commit_cnt, 64'd16);

    $display("[TB] bubble collapse");
    pushItems(64'h51, 5, 10);
    checkOutput("bub_full", 64'(cur_valid), 64'h1F);
    applyStimulus(1'b1, 64'h56, 1'b1, 5'b10111, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("bub_valid", 64'(cur_valid), 64'h07);
    checkOutput("bub_in_ready", 64'(in_ready), 64'h0);
    checkOutput("bub_occ", 64'(occupancy), 64'd3);
    done = ALL_DONE;
    pushItems(64'h56, 5, 10);
    idle(8);
    checkQueue("bub", 64'h5B, 10);
    checkOutput("bub_commit", commit_cnt, 64'd26);

    $display("[TB] partial flush");
    applyStimulus(1'b0, '0, 1'b0, ALL_DONE, 1'b0, 3'd0);
    pushItems(64'h71, 5, 10);
    idle(2);
    checkOutput("pf_full", 64'(occupancy), 64'd5);
    applyStimulus(1'b1, 64'h76, 1'b1, ALL_DONE, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, '0, 1'b1, ALL_DONE, 1'b0, 3'd0);
    checkOutput("pf_valid", 64'(cur_valid), 64'h18);
    checkOutput("pf_occ", 64'(occupancy), 64'd2);
    checkOutput("pf_survivor", cur_data[3*W +: W], 64'h79);
    checkOutput("pf_commit", commit_cnt, 64'd27);
    idle(5);
    checkQueue("pf", 64'h7B, 3);
    checkOutput("pf_commit_drain", commit_cnt, 64'd29);

    $display("[TB] full flush");
    applyStimulus(1'b0, '0, 1'b0, ALL_DONE, 1'b0, 3'd0);
    pushItems(64'h91, 5, 10);
    idle(2);
    checkOutput("ff_out_valid", 64'(out_valid), 64'h1);
    applyStimulus(1'b1, 64'h96, 1'b1, ALL_DONE, 1'b1, 3'd7);
    tick();
    applyStimulus(1'b0, '0, 1'b1, ALL_DONE, 1'b0, 3'd0);
    checkOutput("ff_valid", 64'(cur_valid), 64'h0);
    checkOutput("ff_occ", 64'(occupancy), 64'd0);
    checkOutput("ff_commit", commit_cnt, 64'd29);
    idle(3);
    checkQueue("ff", 64'h0, 0);

    $display("[TB] async reset");
    pushItems(64'hA1, 3, 10);
    idle(6);
    checkQueue("ar_pre", 64'hAB, 3);
    checkOutput("ar_commit_pre", commit_cnt, 64'd32);
    pushItems(64'hB1, 3, 10);
    checkOutput("ar_inflight", 64'(cur_valid), 64'h07);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 64'(cur_valid), 64'h0);
    checkOutput("ar_commit", commit_cnt, 64'h0);
    checkOutput("ar_occ", 64'(occupancy), 64'h0);
    checkOutput("ar_out_valid", 64'(out_valid), 64'h0);
    #10;
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
